// File: rtl/mux_serializer.sv
// mux_serializer: parallel-to-serial converter with valid/ready on both sides.
// A captured word is held in r_hold and one bit per accepted beat is selected
// through a balanced tree of 2:1 mux cells driven by the resolved bit position.

// Two-input mux cell used as the only building block of the selection tree.
module mux (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

module mux_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_data,
  output logic             down_last
);

  localparam int IW     = $clog2(WIDTH);
  localparam int LEAVES = 1 << IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]    r_hold;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_pos;
  logic                w_last;
  logic                w_beat;
  logic                w_load;
  logic                w_tree;
  // Heap-ordered tree nodes: node 0 is the root, leaves occupy LEAVES-1 .. 2*LEAVES-2.
  logic [2*LEAVES-2:0] w_node;

  assign w_last = (r_state == S_SHIFT) && (r_idx == LAST_IDX);
  assign w_beat = (r_state == S_SHIFT) && down_ready;
  assign w_load = up_valid && up_ready;

  // Resolve the counter into the physical bit position for the chosen bit order.
  always_comb begin
    if (LSB_FIRST) w_pos = r_idx;
    else           w_pos = LAST_IDX - r_idx;
  end

  // Leaves: hold register bits, padded with zeros up to the next power of two.
  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < WIDTH) begin : g_used
      assign w_node[LEAVES-1+j] = r_hold[j];
    end else begin : g_pad
      assign w_node[LEAVES-1+j] = 1'b0;
    end
  end

  // Internal nodes: the level nearest the root steers with the MSB of w_pos,
  // the level nearest the leaves with bit 0.
  for (genvar d = 0; d < IW; d++) begin : g_lvl
    for (genvar m = 0; m < (1 << d); m++) begin : g_node
      mux u_mux (
        .i_a   (w_node[2*((1<<d)-1+m)+1]),
        .i_b   (w_node[2*((1<<d)-1+m)+2]),
        .i_sel (w_pos[IW-1-d]),
        .o_y   (w_node[(1<<d)-1+m])
      );
    end
  end

  assign w_tree = w_node[0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: leave SHIFT only when the last bit goes out with no word waiting.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_next = S_SHIFT;
      S_SHIFT: if (w_beat && w_last && !up_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and serial outputs; up_ready in SHIFT follows down_ready combinationally
  // so a new word can be taken on the same edge the last bit leaves.
  always_comb begin
    up_ready   = 1'b0;
    down_valid = 1'b0;
    down_data  = 1'b0;
    down_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        up_ready = !rst;
      end
      S_SHIFT: begin
        down_valid = 1'b1;
        down_data  = w_tree;
        down_last  = w_last;
        up_ready   = down_ready && w_last;
      end
      default: ;
    endcase
  end

  // Hold register and bit index: capture on accept, advance on each non-final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_idx  <= '0;
    end else if (w_load) begin
      r_hold <= up_data;
      r_idx  <= '0;
    end else if (w_beat && !w_last) begin
      r_idx  <= r_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Testbench for mux_serializer: directed scenarios on an 8-bit LSB-first
// instance and a 5-bit MSB-first instance, then randomized traffic on both
// checked against a bit-queue reference model.
module tb_mux_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid, up_ready, down_valid, down_ready, down_data, down_last;
  logic [7:0] up_data;
  logic       b_up_valid, b_up_ready, b_down_valid, b_down_ready, b_down_data, b_down_last;
  logic [4:0] b_up_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .down_last(down_last)
  );

  mux_serializer #(.WIDTH(5), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data),
    .down_valid(b_down_valid), .down_ready(b_down_ready),
    .down_data(b_down_data), .down_last(b_down_last)
  );

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
    b_up_valid = 1'b0; b_up_data = '0; b_down_ready = 1'b0;
    repeat (2) to_pos();
    rst = 1'b0;
    to_neg();
    total++;
    if ({up_ready, down_valid, b_up_ready, b_down_valid} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_release got=%b want=1010", {up_ready, down_valid, b_up_ready, b_down_valid});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({up_ready, down_valid, down_data, down_last} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async got=%b want=0000", {up_ready, down_valid, down_data, down_last});
    end
    to_pos();
    to_pos();
    rst = 1'b0;
    to_neg();
    total++;
    if ({up_ready, down_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_rerelease got=%b want=10", {up_ready, down_valid});
    end
  endtask

  task automatic test_single();
    logic [0:7] exp_s;
    exp_s = 8'b1010_0101;
    to_pos();
    up_valid = 1'b1; up_data = 8'hA5; down_ready = 1'b1;
    to_neg();
    total++;
    if (up_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_accept got=%b want=1", up_ready);
    end
    to_pos();
    up_valid = 1'b0; up_data = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      to_neg();
      total++;
      if ({down_valid, down_data, down_last, up_ready} !== {1'b1, exp_s[i], i == 7, i == 7}) begin
        bad++;
        $display("FAIL single_beat%0d got=%b want=%b", i,
                 {down_valid, down_data, down_last, up_ready}, {1'b1, exp_s[i], i == 7, i == 7});
      end
      to_pos();
    end
    to_neg();
    total++;
    if ({down_valid, down_data, down_last} !== 3'b000) begin
      bad++;
      $display("FAIL single_after got=%b want=000", {down_valid, down_data, down_last});
    end
  endtask

  task automatic test_back_to_back();
    logic [0:15] exp_s;
    logic        lst;
    exp_s = 16'b0011_1100_1100_0011;
    to_pos();
    up_valid = 1'b1; up_data = 8'h3C; down_ready = 1'b1;
    to_neg();
    total++;
    if (up_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept got=%b want=1", up_ready);
    end
    to_pos();
    up_data = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      lst = (i == 7) || (i == 15);
      to_neg();
      total++;
      if ({down_valid, down_data, down_last, up_ready} !== {1'b1, exp_s[i], lst, lst}) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%b want=%b", i,
                 {down_valid, down_data, down_last, up_ready}, {1'b1, exp_s[i], lst, lst});
      end
      to_pos();
      if (i == 7) up_valid = 1'b0;
    end
    to_neg();
    total++;
    if (down_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after got=%b want=0", down_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [0:7] exp_s;
    exp_s = 8'b0000_1111;
    to_pos();
    up_valid = 1'b1; up_data = 8'hF0; down_ready = 1'b1;
    to_pos();
    up_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        down_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          to_neg();
          total++;
          if ({down_valid, down_data, down_last, up_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL stall%0d got=%b want=1000", s, {down_valid, down_data, down_last, up_ready});
          end
          to_pos();
        end
        down_ready = 1'b1;
      end
      to_neg();
      total++;
      if ({down_valid, down_data, down_last} !== {1'b1, exp_s[i], i == 7}) begin
        bad++;
        $display("FAIL bp_beat%0d got=%b want=%b", i,
                 {down_valid, down_data, down_last}, {1'b1, exp_s[i], i == 7});
      end
      to_pos();
    end
    to_neg();
    total++;
    if (down_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_after got=%b want=0", down_valid);
    end
  endtask

  task automatic test_reset_mid();
    to_pos();
    up_valid = 1'b1; up_data = 8'hFF; down_ready = 1'b1;
    to_pos();
    up_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      total++;
      if ({down_valid, down_data} !== 2'b11) begin
        bad++;
        $display("FAIL rstmid_beat%0d got=%b want=11", i, {down_valid, down_data});
      end
      to_pos();
    end
    to_neg();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({up_ready, down_valid, down_data, down_last} !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_async got=%b want=0000", {up_ready, down_valid, down_data, down_last});
    end
    to_pos();
    rst = 1'b0;
    up_valid = 1'b1; up_data = 8'h01;
    to_neg();
    total++;
    if (up_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_accept got=%b want=1", up_ready);
    end
    to_pos();
    up_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      to_neg();
      total++;
      if ({down_valid, down_data, down_last} !== {1'b1, i == 0, i == 7}) begin
        bad++;
        $display("FAIL fresh_beat%0d got=%b want=%b", i,
                 {down_valid, down_data, down_last}, {1'b1, i == 0, i == 7});
      end
      to_pos();
    end
  endtask

  task automatic test_msb_first_w5();
    logic [0:4] exp_s;
    exp_s = 5'b10011;
    to_pos();
    b_up_valid = 1'b1; b_up_data = 5'b10011; b_down_ready = 1'b1;
    to_neg();
    total++;
    if (b_up_ready !== 1'b1) begin
      bad++;
      $display("FAIL w5_accept got=%b want=1", b_up_ready);
    end
    to_pos();
    b_up_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      total++;
      if ({b_down_valid, b_down_data, b_down_last} !== {1'b1, exp_s[i], i == 4}) begin
        bad++;
        $display("FAIL w5_beat%0d got=%b want=%b", i,
                 {b_down_valid, b_down_data, b_down_last}, {1'b1, exp_s[i], i == 4});
      end
      to_pos();
    end
    to_neg();
    total++;
    if (b_down_valid !== 1'b0) begin
      bad++;
      $display("FAIL w5_after got=%b want=0", b_down_valid);
    end
  endtask

  task automatic test_random();
    bit qa[$];
    bit qb[$];
    logic ev, ed, el, er;
    for (int c = 0; c < 3000; c++) begin
      to_pos();
      up_valid     = ($urandom_range(0, 3) != 0);
      up_data      = 8'($urandom);
      down_ready   = ($urandom_range(0, 3) != 0);
      b_up_valid   = ($urandom_range(0, 3) != 0);
      b_up_data    = 5'($urandom);
      b_down_ready = ($urandom_range(0, 2) != 0);
      to_neg();
      // Instance A: LSB first, 8 bits.
      ev = (qa.size() != 0);
      ed = ev ? qa[0] : 1'b0;
      el = (qa.size() == 1);
      er = !ev || (down_ready && el);
      total++;
      if ({down_valid, down_data, down_last, up_ready} !== {ev, ed, el, er}) begin
        bad++;
        $display("FAIL rand_a cyc%0d got=%b want=%b", c,
                 {down_valid, down_data, down_last, up_ready}, {ev, ed, el, er});
      end
      if (ev && down_ready) void'(qa.pop_front());
      if (up_valid && er) for (int k = 0; k < 8; k++) qa.push_back(up_data[k]);
      // Instance B: MSB first, 5 bits.
      ev = (qb.size() != 0);
      ed = ev ? qb[0] : 1'b0;
      el = (qb.size() == 1);
      er = !ev || (b_down_ready && el);
      total++;
      if ({b_down_valid, b_down_data, b_down_last, b_up_ready} !== {ev, ed, el, er}) begin
        bad++;
        $display("FAIL rand_b cyc%0d got=%b want=%b", c,
                 {b_down_valid, b_down_data, b_down_last, b_up_ready}, {ev, ed, el, er});
      end
      if (ev && b_down_ready) void'(qb.pop_front());
      if (b_up_valid && er) for (int k = 4; k >= 0; k--) qb.push_back(b_up_data[k]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_msb_first_w5();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
